// File: rtl/shift_alu_pkg.sv
// Shared types and constants for the shift/rotate ALU arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shift_alu_pkg;

  // Operand and shift-amount widths of the shared ALU
  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  // ALU operation codes, passed through unchanged to the ALU
  typedef logic [1:0] op_t;
  localparam op_t OP_SLL = 2'b00;
  localparam op_t OP_SRL = 2'b01;
  localparam op_t OP_RL  = 2'b10;
  localparam op_t OP_RR  = 2'b11;

  // Sequencer states: waiting for a request, ALU evaluating, response pending
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant.sv
// Round-robin priority picker: first requester at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is advisory, the caller decides when it is taken.
module rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] k;

  // Scan requesters starting at ptr and stop at the first active one
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = IDW'((int'(ptr) + i) % NREQ);
      if (!any && req[k]) begin
        grant[k] = 1'b1;
        idx      = k;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_alu_arbiter.sv
// Shares one combinational shift/rotate ALU between NREQ requesters, round-robin.
// Latency: accept cycle + 2 to rsp_valid; one operation in flight, issue every 3 cycles at best.
// Backpressure: response held while rsp_ready=0; no grants until it is taken. Optional SHIFT_ALU_ARB_PERF_EN adds op_count.
module shift_alu_arbiter
  import shift_alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_choice,
  input  logic [DATA_W*NREQ-1:0]    req_data,
  input  logic [SHAMT_W*NREQ-1:0]   req_shift_by,
  output logic [1:0]                alu_choice,
  output logic [DATA_W-1:0]         alu_i0,
  output logic [SHAMT_W-1:0]        alu_shift_by,
  input  logic [DATA_W-1:0]         alu_o,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [IDW-1:0]            rsp_id,
  output logic                      busy
`ifdef SHIFT_ALU_ARB_PERF_EN
  ,
  output logic [15:0]               op_count
`endif
);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_nxt;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            accept;
  logic            rsp_hs;

  logic [1:0]         choice_arr [NREQ];
  logic [DATA_W-1:0]  data_arr   [NREQ];
  logic [SHAMT_W-1:0] shamt_arr  [NREQ];

  // Split the packed per-requester fields so the winner can be indexed directly
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign choice_arr[g] = req_choice[2*g +: 2];
    assign data_arr[g]   = req_data[DATA_W*g +: DATA_W];
    assign shamt_arr[g]  = req_shift_by[SHAMT_W*g +: SHAMT_W];
  end

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Pointer moves to the slot just after the winner so it has lowest priority next
  assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign busy = (state != IDLE);

  // Next-state and handshake decode; grants only offered in IDLE and out of reset
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any && !rst) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, operand latches towards the ALU, and the response register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      alu_choice   <= '0;
      alu_i0       <= '0;
      alu_shift_by <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_choice   <= choice_arr[gnt_idx];
        alu_i0       <= data_arr[gnt_idx];
        alu_shift_by <= shamt_arr[gnt_idx];
        rsp_id       <= gnt_idx;
        rr_ptr       <= ptr_nxt;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_o;
        rsp_valid <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_ALU_ARB_PERF_EN
  // Count completed response handshakes; wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (rsp_hs) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule
